// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: ADC-domain write-side controller for the waveform RAM.
// Decimates incoming samples, waits for a level/edge trigger (or an auto
// timeout), writes one frame to addresses 0..LEN-1, then holds the frame
// until the display side acknowledges it.
module adc_capture_ctrl #(
    parameter int LEN          = 800,
    parameter int DECIM_W      = 16,
    parameter int AUTO_TIMEOUT = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         adc_data,
    input  logic               adc_valid,
    input  logic               run,
    input  logic               single,
    input  logic [7:0]         trig_level,
    input  logic               trig_edge,
    input  logic               trig_auto,
    input  logic [DECIM_W-1:0] decim,
    input  logic               frame_ack,
    output logic               wr_en,
    output logic [9:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               frame_done,
    output logic               busy,
    output logic               triggered
);

    localparam int TCNT_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0]  TIMEOUT_LAST = TCNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [9:0]         ADDR_LAST    = 10'(LEN - 1);
    localparam logic [DECIM_W-1:0] DCNT_ONE     = DECIM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
    logic [7:0]          prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [9:0]          addr_q, addr_d;
    logic                single_latched_q, single_latched_d;
    logic                wr_en_q, wr_en_d;
    logic [9:0]          wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                triggered_q, triggered_d;

    logic                strobe;
    logic                trig_hit;
    logic                timeout_hit;
    logic                arm_entry;

    // Level crossing between the previous and current strobed sample.
    function automatic logic trig_cross(input logic [7:0] prev,
                                        input logic [7:0] cur,
                                        input logic [7:0] lvl,
                                        input logic       falling);
        if (falling) begin
            return (prev > lvl) && (cur <= lvl);
        end
        return (prev < lvl) && (cur >= lvl);
    endfunction

    // Timeout count saturates so a long wait with auto disabled cannot wrap.
    function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
        if (v >= TIMEOUT_LAST) begin
            return TIMEOUT_LAST;
        end
        return v + TCNT_W'(1);
    endfunction

    // Next-state, counters and registered write outputs.
    always_comb begin
        state_d          = state_q;
        dcnt_d           = dcnt_q;
        prev_d           = prev_q;
        prev_valid_d     = prev_valid_q;
        tcnt_d           = tcnt_q;
        addr_d           = addr_q;
        single_latched_d = single_latched_q;
        wr_en_d          = 1'b0;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        triggered_d      = triggered_q;
        arm_entry        = 1'b0;

        strobe      = adc_valid && (dcnt_q == '0);
        trig_hit    = strobe && prev_valid_q &&
                      trig_cross(prev_q, adc_data, trig_level, trig_edge);
        timeout_hit = strobe && trig_auto && (tcnt_q == TIMEOUT_LAST);

        // Decimator: reload on the kept sample, count down on the others.
        if (adc_valid) begin
            dcnt_d = strobe ? decim : (dcnt_q - DCNT_ONE);
        end

        if (strobe) begin
            prev_d       = adc_data;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (single) begin
                    single_latched_d = 1'b1;
                    state_d          = S_ARM;
                    arm_entry        = 1'b1;
                end else if (run) begin
                    state_d   = S_ARM;
                    arm_entry = 1'b1;
                end
            end
            S_ARM: begin
                if (!run && !single_latched_q) begin
                    state_d = S_IDLE;
                end else if (trig_hit || timeout_hit) begin
                    // A real trigger wins over a simultaneous timeout.
                    state_d     = S_CAPTURE;
                    triggered_d = trig_hit;
                    wr_en_d     = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = adc_data;
                    addr_d      = 10'd1;
                end else if (strobe) begin
                    tcnt_d = sat_inc(tcnt_q);
                end
            end
            S_CAPTURE: begin
                // Run is not sampled here: a started frame always completes.
                if (strobe) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = adc_data;
                    addr_d    = addr_q + 10'd1;
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (frame_ack) begin
                    single_latched_d = 1'b0;
                    if (run && !single_latched_q) begin
                        state_d   = S_ARM;
                        arm_entry = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every arming starts from a clean decimation phase, no history and
        // a fresh timeout.
        if (arm_entry) begin
            dcnt_d       = '0;
            prev_valid_d = 1'b0;
            tcnt_d       = '0;
        end

        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d == S_ARM) || (state_d == S_CAPTURE);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dcnt_q           <= '0;
            prev_valid_q     <= 1'b0;
            tcnt_q           <= '0;
            addr_q           <= '0;
            single_latched_q <= 1'b0;
            wr_en_q          <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            frame_done_q     <= 1'b0;
            busy_q           <= 1'b0;
            triggered_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            dcnt_q           <= dcnt_d;
            prev_valid_q     <= prev_valid_d;
            tcnt_q           <= tcnt_d;
            addr_q           <= addr_d;
            single_latched_q <= single_latched_d;
            wr_en_q          <= wr_en_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            frame_done_q     <= frame_done_d;
            busy_q           <= busy_d;
            triggered_q      <= triggered_d;
        end
    end

    // Previous strobed sample; only meaningful while prev_valid_q is set.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign triggered  = triggered_q;

endmodule
